// File: rtl/proc_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, opcodes,
// default handshake timeout and opcode classification.
package proc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALTED = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU  = 3'd0,
    CL_MEM  = 3'd1,
    CL_JUMP = 3'd2,
    CL_NOP  = 3'd3,
    CL_HALT = 3'd4
  } op_class_t;

  localparam logic [3:0] OP_LOAD  = 4'b0111;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_JUMP  = 4'b1001;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam int DEFAULT_TIMEOUT = 15;

  function automatic op_class_t classify(input logic [3:0] op);
    op_class_t cls;
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b0110: cls = CL_ALU;
      OP_LOAD, OP_STORE:         cls = CL_MEM;
      OP_JUMP:                   cls = CL_JUMP;
      OP_HALT:                   cls = CL_HALT;
      default:                   cls = CL_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Handshake watchdog: counts cycles spent waiting for an ack and flags the
// cycle that would be the TIMEOUT-th one without it.
module wait_timer
  import proc_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_r;

  // Wait-cycle counter; holds at the limit since the FSM leaves the wait state then
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (tick && (count_r != LIMIT)) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LIMIT);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback
// control FSM with handshake watchdog and retired-instruction counter.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ir,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        pc_en,
  output logic        pc_load,
  output logic        busy,
  output logic        err,
  output logic [2:0]  state,
  output logic [15:0] retire_cnt
);

  state_t      state_r, state_next_s, retire_dest_s;
  logic [15:0] ir_r, ir_next_s, retire_cnt_r;
  logic        retire_s, waiting_s, ack_s, expired_s, is_store_s, store_ack_s;
  logic        imem_req_r, dmem_req_r, dmem_we_r, rf_we_r, pc_en_r, pc_load_r;
  logic        busy_r, err_r;
  op_class_t   op_s, op_next_s;

  assign op_s          = classify(ir_r[3:0]);
  assign op_next_s     = classify(ir_next_s[3:0]);
  assign is_store_s    = (ir_r[3:0] == OP_STORE);
  assign waiting_s     = (state_r == ST_FETCH) || (state_r == ST_MEM);
  assign ack_s         = ((state_r == ST_FETCH) && imem_ack) || ((state_r == ST_MEM) && dmem_ack);
  assign retire_dest_s = halt_req ? ST_IDLE : ST_FETCH;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!waiting_s || ack_s),
    .tick    (waiting_s && !ack_s),
    .expired (expired_s)
  );

  // Next-state, instruction latch and retire decision
  always_comb begin
    state_next_s = state_r;
    ir_next_s    = ir_r;
    retire_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_FETCH;
        else       state_next_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          ir_next_s    = imem_rdata;
          state_next_s = ST_DECODE;
        end else if (expired_s) begin
          state_next_s = ST_ERROR;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: state_next_s = ST_EXEC;
      ST_EXEC: begin
        case (op_s)
          CL_ALU:  state_next_s = ST_WB;
          CL_MEM:  state_next_s = ST_MEM;
          CL_JUMP, CL_NOP: begin
            retire_s     = 1'b1;
            state_next_s = retire_dest_s;
          end
          CL_HALT: begin
            retire_s     = 1'b1;
            state_next_s = ST_HALTED;
          end
          default: state_next_s = ST_ERROR;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (is_store_s) begin
            retire_s     = 1'b1;
            state_next_s = retire_dest_s;
          end else begin
            state_next_s = ST_WB;
          end
        end else if (expired_s) begin
          state_next_s = ST_ERROR;
        end else begin
          state_next_s = ST_MEM;
        end
      end
      ST_WB: begin
        retire_s     = 1'b1;
        state_next_s = retire_dest_s;
      end
      ST_HALTED: state_next_s = ST_HALTED;
      ST_ERROR:  state_next_s = ST_ERROR;
      default:   state_next_s = ST_ERROR;
    endcase
  end

  // State, datapath registers and outputs pre-decoded from the upcoming state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      ir_r         <= 16'h0000;
      retire_cnt_r <= 16'h0000;
      err_r        <= 1'b0;
      imem_req_r   <= 1'b0;
      dmem_req_r   <= 1'b0;
      dmem_we_r    <= 1'b0;
      rf_we_r      <= 1'b0;
      pc_en_r      <= 1'b0;
      pc_load_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      ir_r         <= ir_next_s;
      retire_cnt_r <= retire_s ? (retire_cnt_r + 16'h0001) : retire_cnt_r;
      err_r        <= err_r || (state_next_s == ST_ERROR);
      imem_req_r   <= (state_next_s == ST_FETCH);
      dmem_req_r   <= (state_next_s == ST_MEM);
      dmem_we_r    <= (state_next_s == ST_MEM) && (ir_next_s[3:0] == OP_STORE);
      rf_we_r      <= (state_next_s == ST_WB);
      pc_en_r      <= (state_next_s == ST_WB) ||
                      ((state_next_s == ST_EXEC) && ((op_next_s == CL_NOP) || (op_next_s == CL_HALT)));
      pc_load_r    <= (state_next_s == ST_EXEC) && (op_next_s == CL_JUMP);
      busy_r       <= (state_next_s != ST_IDLE);
    end
  end

  // A store retires on the ack cycle itself, so its PC strobe follows the ack
  assign store_ack_s = (state_r == ST_MEM) && dmem_ack && is_store_s;

  assign imem_req   = imem_req_r;
  assign dmem_req   = dmem_req_r;
  assign dmem_we    = dmem_we_r;
  assign rf_we      = rf_we_r;
  assign pc_en      = pc_en_r || store_ack_s;
  assign pc_load    = pc_load_r;
  assign busy       = busy_r;
  assign err        = err_r;
  assign ir         = ir_r;
  assign state      = state_r;
  assign retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle vector table plus hand-written
// timeout, halt, reset-abort and counter-wrap sequences.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, halt_req, imem_ack, dmem_ack;
  logic [15:0] imem_rdata;
  logic        imem_req, dmem_req, dmem_we, rf_we, pc_en, pc_load, busy, err;
  logic [15:0] ir, retire_cnt;
  logic [2:0]  state;
  logic [7:0]  flags;

  int checks   = 0;
  int failures = 0;

  instr_sequencer #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt_req   (halt_req),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .rf_we      (rf_we),
    .pc_en      (pc_en),
    .pc_load    (pc_load),
    .busy       (busy),
    .err        (err),
    .state      (state),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  // {imem_req, dmem_req, dmem_we, rf_we, pc_en, pc_load, busy, err}
  assign flags = {imem_req, dmem_req, dmem_we, rf_we, pc_en, pc_load, busy, err};

  typedef struct packed {
    logic        start;
    logic        halt;
    logic        iack;
    logic [15:0] rdata;
    logic        dack;
    logic [2:0]  st;
    logic [7:0]  fl;
    logic [15:0] cnt;
    logic [15:0] ir_e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic h, input logic ia, input logic [15:0] rd,
                              input logic da, input logic [2:0] st, input logic [7:0] fl,
                              input logic [15:0] cnt, input logic [15:0] ir_e);
    vec_t v;
    v.start = s; v.halt = h; v.iack = ia; v.rdata = rd; v.dack = da;
    v.st = st; v.fl = fl; v.cnt = cnt; v.ir_e = ir_e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and settle before sampling
  task automatic step(input logic s, input logic h, input logic ia, input logic [15:0] rd, input logic da);
    @(negedge clk);
    start = s; halt_req = h; imem_ack = ia; imem_rdata = rd; dmem_ack = da;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000; dmem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", state, 3'd0);
    check("reset_flags", flags, 8'b00000000);
    check("reset_ir", ir, 16'h0000);
    check("reset_cnt", retire_cnt, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    // ALU 0x0013, jump 0x0019, load 0x0007 (ack +3), NOP 0x000A, store 0x0008 with halt_req
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 8'b00000000, 16'd0, 16'h0000));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 8'b00000000, 16'd0, 16'h0000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0013, 1'b0, 3'd1, 8'b10000010, 16'd0, 16'h0000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 3'd2, 8'b00000010, 16'd0, 16'h0013));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd3, 8'b00000010, 16'd0, 16'h0013));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd5, 8'b00011010, 16'd0, 16'h0013));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0019, 1'b0, 3'd1, 8'b10000010, 16'd1, 16'h0013));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd2, 8'b00000010, 16'd1, 16'h0019));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd3, 8'b00000110, 16'd1, 16'h0019));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0007, 1'b0, 3'd1, 8'b10000010, 16'd2, 16'h0019));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd2, 8'b00000010, 16'd2, 16'h0007));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd3, 8'b00000010, 16'd2, 16'h0007));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd4, 8'b01000010, 16'd2, 16'h0007));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd4, 8'b01000010, 16'd2, 16'h0007));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd4, 8'b01000010, 16'd2, 16'h0007));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd4, 8'b01000010, 16'd2, 16'h0007));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd5, 8'b00011010, 16'd2, 16'h0007));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 16'h000A, 1'b0, 3'd1, 8'b10000010, 16'd3, 16'h0007));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd2, 8'b00000010, 16'd3, 16'h000A));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd3, 8'b00001010, 16'd3, 16'h000A));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0008, 1'b0, 3'd1, 8'b10000010, 16'd4, 16'h000A));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd2, 8'b00000010, 16'd4, 16'h0008));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd3, 8'b00000010, 16'd4, 16'h0008));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd4, 8'b01101010, 16'd4, 16'h0008));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 8'b00000000, 16'd5, 16'h0008));

    foreach (tbl[i]) begin
      step(tbl[i].start, tbl[i].halt, tbl[i].iack, tbl[i].rdata, tbl[i].dack);
      check($sformatf("row%0d_state", i), state, tbl[i].st);
      check($sformatf("row%0d_flags", i), flags, tbl[i].fl);
      check($sformatf("row%0d_cnt", i), retire_cnt, tbl[i].cnt);
      check($sformatf("row%0d_ir", i), ir, tbl[i].ir_e);
    end

    // Fetch ack withheld for 15 cycles -> ERROR, which ignores later acks
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      check($sformatf("to_fetch%0d_state", i), state, 3'd1);
    end
    step(1'b0, 1'b0, 1'b1, 16'h0013, 1'b1);
    check("to_error_state", state, 3'd7);
    check("to_error_flags", flags, 8'b00000011);
    step(1'b1, 1'b0, 1'b1, 16'h0013, 1'b1);
    check("to_error_stuck", state, 3'd7);

    // Ack on the 15th cycle wins over the timeout; halt opcode then parks in HALTED
    do_reset();
    #1;
    check("err_cleared_by_reset", err, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 16'h000F, 1'b0);
    check("ack15_fetch_state", state, 3'd1);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("ack15_decode_state", state, 3'd2);
    check("ack15_err", err, 1'b0);
    check("ack15_ir", ir, 16'h000F);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("halt_exec_flags", flags, 8'b00001010);
    step(1'b1, 1'b0, 1'b1, 16'h0013, 1'b1);
    check("halted_state", state, 3'd6);
    check("halted_flags", flags, 8'b00000010);
    check("halted_cnt", retire_cnt, 16'd1);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("halted_stuck", state, 3'd6);

    // Reset asserted while a load waits in MEM
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0007, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("abort_mem_before", flags, 8'b01000010);
    #1;
    reset = 1'b0;
    #1;
    check("abort_state", state, 3'd0);
    check("abort_flags", flags, 8'b00000000);
    check("abort_ir", ir, 16'h0000);
    check("abort_cnt", retire_cnt, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    check("abort_after_flags", flags, 8'b00000000);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("abort_after_state", state, 3'd0);

    // Counter preloaded to 0xFFFF wraps on the next retire (a jump)
    @(negedge clk);
    force dut.retire_cnt_r = 16'hFFFF;
    #1;
    release dut.retire_cnt_r;
    #1;
    check("wrap_preload", retire_cnt, 16'hFFFF);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0019, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("jump_exec_flags", flags, 8'b00000110);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("jump_next_state", state, 3'd1);
    check("wrap_cnt", retire_cnt, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles waiting for imem_ack/dmem_ack before error.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  leave IDLE and begin fetching.
REQ-005 halt_req  input  1  stop after the current instruction retires.
REQ-006 imem_req  output  1  instruction fetch request, held until ack.
REQ-007 imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-008 imem_rdata  input  16  fetched instruction word.
REQ-009 ir  output  16  latched instruction register.
REQ-010 dmem_req  output  1  data memory request, held until ack.
REQ-011 dmem_we  output  1  store qualifier, valid with dmem_req.
REQ-012 dmem_ack  input  1  data access complete.
REQ-013 rf_we  output  1  register-file write strobe.
REQ-014 pc_en  output  1  PC += 1 strobe.
REQ-015 pc_load  output  1  PC <= jump target strobe.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 err  output  1  sticky handshake-timeout flag.
REQ-018 state  output  3  current state encoding, for debug.
REQ-019 retire_cnt  output  16  count of retired instructions.

Function
REQ-020 Opcode is ir[3:0]: 0000-0110 ALU (writes register); 0111 load; 1000 store; 1001 jump; 1111 halt; 1010-1110 NOP.
REQ-021 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR.
REQ-022 IDLE: start=1 -> FETCH; otherwise remain in IDLE.
REQ-023 FETCH: imem_req=1; on imem_ack, ir <= imem_rdata and -> DECODE.
REQ-024 DECODE: one cycle, no strobes -> EXEC.
REQ-025 EXEC, one cycle, routed by opcode:
- ALU -> WB.
- load/store -> MEM.
- jump: pc_load=1 and retire.
- NOP: pc_en=1 and retire.
- halt: pc_en=1 and retire -> HALTED.
REQ-026 MEM: dmem_req=1 with dmem_we=(opcode==1000); on dmem_ack, load -> WB; store asserts pc_en and retires.
REQ-027 WB: one cycle, rf_we=1 and pc_en=1, then retire.
REQ-028 Retire means next state FETCH, or IDLE if halt_req=1 in that cycle (halt opcode still -> HALTED).
REQ-029 pc_en, pc_load, rf_we: single-cycle pulses, registered-state decoded (Moore), never asserted together except rf_we with pc_en in WB.
REQ-030 Latency with same-cycle ack: ALU 4 cycles, load 5, store 4, jump/NOP 3.
REQ-031 retire_cnt increments by 1 in every retire cycle and wraps 0xFFFF -> 0x0000.
REQ-032 Wait counter clears on entry to FETCH/MEM and increments each cycle without ack; at TIMEOUT cycles without ack -> ERROR with err=1.
REQ-033 An ack arriving in the same cycle as the counter reaches TIMEOUT takes priority: normal transition, no error.
REQ-034 Acks outside FETCH/MEM are ignored.
REQ-035 HALTED and ERROR exit only via reset; all requests and strobes are 0 in them.
REQ-036 imem_req and dmem_req are never high in the same cycle.

Reset
REQ-037 reset=0 immediately forces IDLE; ir=0, retire_cnt=0, err=0, wait counter=0, all request/strobe outputs 0, busy=0.
REQ-038 Reset mid-transaction abandons the transaction; no strobe is emitted for the aborted instruction.

Structure
REQ-039 State encoding, opcode constants and default TIMEOUT shall live in shared package proc_pkg.
REQ-040 Handshake watchdog shall be sub-module wait_timer (clear, tick, expired).

Verification
REQ-041 ir=0x0013 (ALU), imem_ack immediate -> rf_we and pc_en in cycle 4; retire_cnt=1.
REQ-042 Load 0x0007, dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, then WB with rf_we=1.
REQ-043 Jump 0x0019 -> pc_load=1 in EXEC, pc_en=0, rf_we=0; next state FETCH.
REQ-044 imem_ack withheld 15 cycles -> ERROR, err=1; ack on the 15th cycle -> DECODE, err=0.
REQ-045 halt_req=1 during store MEM ack -> IDLE after retire; halt opcode 0x000F -> HALTED.
REQ-046 reset pulsed low in MEM -> outputs zero same cycle; retire_cnt preloaded near 0xFFFF wraps to 0.
